// File: rtl/l1_pmem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : l1_cache_pkg                                                 |
// | Description : Shared types and defaults for the L1 pmem arbiter slice.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package l1_cache_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_LINE_WIDTH = 256;
    localparam int unsigned DEF_CNT_WIDTH  = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2,
        ARB_DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    // Round-robin pick; only meaningful when at least one request is pending.
    function automatic requester_t rr_pick(input logic       req_i,
                                           input logic       req_d,
                                           input requester_t last);
        if (req_i && (!req_d || (last == REQ_D))) begin
            return REQ_I;
        end
        return REQ_D;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l1_pmem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : l1_pmem_arbiter_if                                           |
// | Description : I-cache, D-cache and pmem adaptor signals of the arbiter.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface l1_pmem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    // Environment side: both caches and the pmem adaptor.
    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

    // Arbiter side.
    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_address, d_wdata,
        output d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );
endinterface
`default_nettype wire

// File: rtl/l1_pmem_arbiter_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sat_counter                                                  |
// | Description : Up counter with async active-low clear, holds at all-ones.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc_i,
    output logic      [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/l1_pmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : l1_pmem_arbiter                                              |
// | Description : Round-robin share of one pmem port between L1 I$ and D$.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module l1_pmem_arbiter
    import l1_cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    l1_pmem_arbiter_if.slave          bus,
    output logic      [CNT_WIDTH-1:0] i_grant_count,
    output logic      [CNT_WIDTH-1:0] d_grant_count
);

    arb_state_t            state_q, state_d;
    requester_t            last_grant_q, last_grant_d;
    logic                  op_write_q, op_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

    logic                  req_i;
    logic                  req_d;
    logic                  grant_i;
    logic                  grant_d;
    logic                  cmd_read;
    logic                  cmd_write;
    logic                  resp_i;
    logic                  resp_d;

    assign req_i = bus.i_read;
    assign req_d = bus.d_read | bus.d_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= REQ_D;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        cmd_read     = 1'b0;
        cmd_write    = 1'b0;
        resp_i       = 1'b0;
        resp_d       = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (req_i || req_d) begin
                    if (rr_pick(req_i, req_d, last_grant_q) == REQ_I) begin
                        grant_i      = 1'b1;
                        state_d      = ARB_SERVE_I;
                        last_grant_d = REQ_I;
                        addr_d       = bus.i_address;
                        op_write_d   = 1'b0;
                    end else begin
                        grant_d      = 1'b1;
                        state_d      = ARB_SERVE_D;
                        last_grant_d = REQ_D;
                        addr_d       = bus.d_address;
                        wdata_d      = bus.d_wdata;
                        // A write wins over a simultaneous (illegal) read.
                        op_write_d   = bus.d_write;
                    end
                end
            end
            ARB_SERVE_I: begin
                cmd_read = 1'b1;
                if (bus.pmem_resp) begin
                    resp_i  = 1'b1;
                    state_d = ARB_DONE;
                end
            end
            ARB_SERVE_D: begin
                cmd_read  = ~op_write_q;
                cmd_write = op_write_q;
                if (bus.pmem_resp) begin
                    resp_d  = 1'b1;
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Commands decode straight from the state so reset drops them without a clock.
    assign bus.pmem_read    = cmd_read;
    assign bus.pmem_write   = cmd_write;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;

    assign bus.i_rdata = bus.pmem_rdata;
    assign bus.d_rdata = bus.pmem_rdata;
    assign bus.i_resp  = resp_i;
    assign bus.d_resp  = resp_d;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_i_grant_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (grant_i),
        .count_o (i_grant_count)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_d_grant_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (grant_d),
        .count_o (d_grant_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_l1_pmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_l1_pmem_arbiter                                           |
// | Description : Self-checking bench for l1_pmem_arbiter with a txn model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_l1_pmem_arbiter;

    localparam int AW     = 32;
    localparam int LW     = 256;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [CW-1:0] icnt;
    logic [CW-1:0] dcnt;

    always #5 clk = ~clk;

    l1_pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    l1_pmem_arbiter #(
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .i_grant_count (icnt),
        .d_grant_count (dcnt)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: who went last and how many grants each side got.
    bit m_last_d;
    int m_icnt;
    int m_dcnt;

    // Requests the caches currently hold.
    bit          p_i, p_dr, p_dw;
    logic [AW-1:0] p_ia, p_da;
    logic [LW-1:0] p_dd;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        bus.i_read    = p_i;
        bus.i_address = p_ia;
        bus.d_read    = p_dr;
        bus.d_write   = p_dw;
        bus.d_address = p_da;
        bus.d_wdata   = p_dd;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        p_i = 0; p_dr = 0; p_dw = 0;
        p_ia = '0; p_da = '0; p_dd = '0;
        drive();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        repeat (2) tick();
        rst = 1'b1;
        m_last_d = 1'b1;
        m_icnt = 0;
        m_dcnt = 0;
        tick();
    endtask

    // Serve one transaction starting in IDLE with requests already driven.
    task automatic serve(input int delay, input logic [LW-1:0] rd);
        bit            win_d, exp_w;
        logic [AW-1:0] ea;
        logic [LW-1:0] ew;
        win_d = !(p_i && (!(p_dr || p_dw) || m_last_d));
        ea    = win_d ? p_da : p_ia;
        exp_w = win_d && p_dw;
        ew    = p_dd;

        checks++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL idle_cmd: got r=%0b w=%0b want 0/0", bus.pmem_read, bus.pmem_write);
        end

        tick();
        m_last_d = win_d;
        if (win_d) m_dcnt = (m_dcnt < CNTMAX) ? m_dcnt + 1 : CNTMAX;
        else       m_icnt = (m_icnt < CNTMAX) ? m_icnt + 1 : CNTMAX;

        checks++;
        if (bus.pmem_read !== !exp_w || bus.pmem_write !== exp_w) begin
            errors++;
            $display("FAIL grant_cmd: got r=%0b w=%0b want r=%0b w=%0b",
                     bus.pmem_read, bus.pmem_write, !exp_w, exp_w);
        end
        checks++;
        if (icnt !== m_icnt[CW-1:0] || dcnt !== m_dcnt[CW-1:0]) begin
            errors++;
            $display("FAIL grant_counts: got i=%0d d=%0d want i=%0d d=%0d", icnt, dcnt, m_icnt, m_dcnt);
        end
        if (win_d) begin
            checks++;
            if (bus.pmem_wdata !== ew) begin
                errors++;
                $display("FAIL pmem_wdata: got %0h want %0h", bus.pmem_wdata, ew);
            end
        end

        // The served cache wanders its address; the command must not follow.
        if (win_d) bus.d_address = $urandom;
        else       bus.i_address = $urandom;

        for (int c = 0; c <= delay; c++) begin
            checks++;
            if (bus.pmem_address !== ea || bus.pmem_read !== !exp_w || bus.pmem_write !== exp_w ||
                bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
                errors++;
                $display("FAIL hold: got a=%0h r=%0b w=%0b ir=%0b dr=%0b want a=%0h r=%0b w=%0b no resp",
                         bus.pmem_address, bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp,
                         ea, !exp_w, exp_w);
            end
            if (c < delay) tick();
        end

        bus.pmem_rdata = rd;
        bus.pmem_resp  = 1'b1;
        #1;
        checks++;
        if (bus.i_resp !== !win_d || bus.d_resp !== win_d) begin
            errors++;
            $display("FAIL resp_route: got i=%0b d=%0b want i=%0b d=%0b",
                     bus.i_resp, bus.d_resp, !win_d, win_d);
        end
        checks++;
        if (bus.i_rdata !== rd || bus.d_rdata !== rd) begin
            errors++;
            $display("FAIL rdata: got i=%0h d=%0h want %0h", bus.i_rdata, bus.d_rdata, rd);
        end

        tick();
        bus.pmem_resp = 1'b0;
        if (win_d) begin p_dr = 0; p_dw = 0; end
        else       p_i = 0;
        drive();
        #1;
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 ||
            bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
            errors++;
            $display("FAIL done_quiet: got r=%0b w=%0b ir=%0b dr=%0b want all 0",
                     bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp);
        end
        tick();
    endtask

    task automatic test_reset();
        p_i = 1; p_ia = 32'h0000_0040; p_dr = 0; p_dw = 1; p_da = 32'h0000_0080; p_dd = rand_line();
        drive();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 ||
            bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got r=%0b w=%0b ir=%0b dr=%0b want all 0",
                     bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp);
        end
        checks++;
        if (icnt !== '0 || dcnt !== '0 || bus.pmem_address !== '0 || bus.pmem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_regs: got i=%0d d=%0d a=%0h want zeros", icnt, dcnt, bus.pmem_address);
        end
        do_reset();
    endtask

    task automatic test_i_only();
        logic [LW-1:0] a5;
        do_reset();
        p_i = 1; p_ia = 32'h0000_1040;
        drive();
        a5 = {(LW / 8){8'hA5}};
        serve(4, a5);
        checks++;
        if (icnt !== 4'd1 || dcnt !== 4'd0) begin
            errors++;
            $display("FAIL i_only_counts: got i=%0d d=%0d want i=1 d=0", icnt, dcnt);
        end
    endtask

    task automatic test_d_writeback();
        do_reset();
        p_dw = 1; p_da = 32'h0000_2000; p_dd = {(LW / 32){32'h1234_5678}};
        drive();
        serve(3, rand_line());
        checks++;
        if (icnt !== 4'd0 || dcnt !== 4'd1) begin
            errors++;
            $display("FAIL wb_counts: got i=%0d d=%0d want i=0 d=1", icnt, dcnt);
        end
    endtask

    task automatic test_contention();
        do_reset();
        p_i = 1; p_ia = 32'h0000_3000; p_dr = 1; p_da = 32'h0000_4000; p_dd = rand_line();
        drive();
        serve(1, rand_line());
        checks++;
        if (icnt !== 4'd1 || dcnt !== 4'd0) begin
            errors++;
            $display("FAIL first_winner: got i=%0d d=%0d want i=1 d=0", icnt, dcnt);
        end
        for (int n = 0; n < 3; n++) begin
            p_i = 1; p_dr = 1;
            drive();
            serve(n, rand_line());
        end
        checks++;
        if (icnt !== 4'd2 || dcnt !== 4'd2) begin
            errors++;
            $display("FAIL alternation: got i=%0d d=%0d want i=2 d=2", icnt, dcnt);
        end
        // Drain the request left pending by the last alternation.
        if (p_i || p_dr || p_dw) serve(0, rand_line());
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        p_i = 1; p_ia = 32'h0000_5040;
        drive();
        tick();
        checks++;
        if (bus.pmem_read !== 1'b1) begin
            errors++;
            $display("FAIL mid_op_start: got r=%0b want 1", bus.pmem_read);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.pmem_read !== 1'b0 || icnt !== '0 || dcnt !== '0) begin
            errors++;
            $display("FAIL async_reset: got r=%0b i=%0d d=%0d want 0/0/0", bus.pmem_read, icnt, dcnt);
        end
        p_i = 0;
        drive();
        tick();
        rst = 1'b1;
        m_last_d = 1'b1; m_icnt = 0; m_dcnt = 0;
        tick();
        bus.pmem_resp = 1'b1;
        #1;
        checks++;
        if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL late_resp: got ir=%0b dr=%0b r=%0b want 0/0/0", bus.i_resp, bus.d_resp, bus.pmem_read);
        end
        tick();
        bus.pmem_resp = 1'b0;
        tick();
    endtask

    task automatic test_illegal_op();
        do_reset();
        p_dr = 1; p_dw = 1; p_da = 32'h0000_6000; p_dd = rand_line();
        drive();
        serve(2, rand_line());
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if (!p_i && ($urandom_range(0, 1) == 1)) begin
                p_i = 1; p_ia = {$urandom, 5'b0} >> 5 << 5;
            end
            if (!(p_dr || p_dw) && ($urandom_range(0, 1) == 1)) begin
                case ($urandom_range(0, 2))
                    0:       begin p_dr = 1; p_dw = 0; end
                    1:       begin p_dr = 0; p_dw = 1; end
                    default: begin p_dr = 1; p_dw = 1; end
                endcase
                p_da = $urandom & 32'hFFFF_FFE0;
                p_dd = rand_line();
            end
            if (!p_i && !p_dr && !p_dw) begin
                p_i = 1; p_ia = $urandom & 32'hFFFF_FFE0;
            end
            drive();
            serve($urandom_range(0, 3), rand_line());
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int n = 0; n < CNTMAX + 3; n++) begin
            p_i = 1; p_ia = $urandom & 32'hFFFF_FFE0;
            drive();
            serve(0, rand_line());
        end
        checks++;
        if (icnt !== 4'd15 || dcnt !== 4'd0) begin
            errors++;
            $display("FAIL saturation: got i=%0d d=%0d want i=15 d=0", icnt, dcnt);
        end
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        test_reset();
        test_i_only();
        test_d_writeback();
        test_contention();
        test_reset_mid_op();
        test_illegal_op();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/l1_pmem_arbiter.md
Name: l1_pmem_arbiter

Overview:
- Shares the single physical-memory (cacheline adaptor) port between the L1 instruction cache and the L1 data cache.
- Accepts whole-cacheline read requests from the I-cache control, and read/write (writeback) requests from the D-cache control.
- Serialises them onto pmem one transaction at a time, with round-robin arbitration on contention.
- Routes pmem_rdata/pmem_resp back to the granted requester and keeps per-requester grant counters for performance analysis.

Parameters:
- ADDR_WIDTH, 32, byte address width of cacheline requests.
- LINE_WIDTH, 256, cacheline data width in bits.
- CNT_WIDTH, 32, width of grant counters.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- rst  in  1  asynchronous, active-low reset.
- i_read  in  1  I-cache cacheline read request; held until i_resp.
- i_address  in  ADDR_WIDTH  I-cache line address.
- i_rdata  out  LINE_WIDTH  line returned to I-cache.
- i_resp  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache cacheline read request; held until d_resp.
- d_write  in  1  D-cache writeback request; held until d_resp.
- d_address  in  ADDR_WIDTH  D-cache line address.
- d_wdata  in  LINE_WIDTH  writeback line.
- d_rdata  out  LINE_WIDTH  line returned to D-cache.
- d_resp  out  1  one-cycle completion pulse to D-cache.
- pmem_read  out  1  read command to adaptor.
- pmem_write  out  1  write command to adaptor.
- pmem_address  out  ADDR_WIDTH  registered command address.
- pmem_wdata  out  LINE_WIDTH  registered write line.
- pmem_rdata  in  LINE_WIDTH  line from adaptor, valid with pmem_resp.
- pmem_resp  in  1  adaptor completion pulse.
- i_grant_count  out  CNT_WIDTH  number of I-cache grants.
- d_grant_count  out  CNT_WIDTH  number of D-cache grants.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, DONE.
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=D, so the I-cache wins the first contended arbitration.
  - Command registers cleared; counters cleared.
  - pmem_read=pmem_write=i_resp=d_resp=0 immediately, with no clock required.
  - Reset mid-transaction abandons the transaction; a late pmem_resp after reset in IDLE is ignored.
- IDLE:
  - Only i_read → SERVE_I.
  - Only d_read|d_write → SERVE_D.
  - Both pending → grant the requester not equal to last_grant.
  - On grant edge: latch address; latch d_wdata and the op (write if d_write, else read); update last_grant; increment that requester's counter.
- d_read and d_write both high is illegal; d_write takes precedence.
- SERVE_I:
  - pmem_read=1, pmem_address=latched.
  - On pmem_resp: i_rdata=pmem_rdata combinationally, i_resp=1 that cycle, next DONE.
- SERVE_D:
  - Drives pmem_read or pmem_write per the latched op; pmem_wdata=latched.
  - On pmem_resp: d_resp=1; d_rdata=pmem_rdata for reads; next DONE.
- DONE: exactly one cycle, no grant, all commands low (lets the served cache drop its request); → IDLE.
- Latency: request-to-pmem command is 1 cycle. Back-to-back transactions have a 2-cycle gap (DONE + IDLE grant).
- pmem_read and pmem_write are never high together. Commands stay stable while a transaction is outstanding, even if requester inputs change.
- i_rdata/d_rdata mirror pmem_rdata at all times; only resp qualifies them. A resp is never asserted to the non-granted requester.
- Counters saturate at all-ones (no wrap).
- A request dropped before grant is simply not served. A request dropped after grant still completes on pmem; the resp is issued regardless.

Decomposition:
- Shared package l1_cache_pkg: arb_state_t enum, requester_t enum {REQ_I, REQ_D}, LINE_WIDTH and ADDR_WIDTH defaults.
- One natural sub-module: sat_counter (parameterised width, async active-low clear, increment enable, saturation), instantiated twice.
- FSM, command registers and response routing stay in the top module.

Test Plan:
- I-only: i_read, i_address=0x0000_1040; pmem_resp after 4 cycles with rdata=0xA5…A5 → pmem_read 1 cycle after request, address 0x1040, i_resp pulse with i_rdata=0xA5…A5, d_resp=0, i_grant_count=1.
- D writeback: d_write, address 0x0000_2000, wdata=0x1234…; pmem_resp after 3 cycles → pmem_write only, pmem_wdata matches, d_resp one cycle, then DONE, IDLE.
- Contention: i_read and d_read both high from reset → I served first, then D. Repeat with both held → strict alternation; counters equal (2/2 after 4 transactions).
- Stability: change d_address to 0xDEAD_BEE0 during SERVE_D → pmem_address keeps the latched value until pmem_resp.
- Reset mid-op: drop rst during SERVE_I between edges → pmem_read falls asynchronously, counters read 0. A subsequent pmem_resp pulse produces no i_resp/d_resp.
- Saturation and illegal op: preload counter near max (CNT_WIDTH=4) → stops at 15. d_read=d_write=1 → pmem_write only.
